data_mem_master: RTL and testbench

Initiator side of the single-port synchronous data RAM interface. Accepts byte, halfword and word load/store requests from the MIPS datapath. Translates each request into word-wide RAM accesses, including read-modify-write for sub-word stores and sign or zero extension for sub-word loads. Sits between the datapath's memory stage and the RAM's `address`/`data`/`wren`/`q` ports.

---
 rtl/data_mem_if.sv | 30 +++
 rtl/data_mem_master.sv | 169 ++++++++++++++++
 tb/tb_data_mem_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Bus between the datapath memory stage and data_mem_master, plus the RAM-side
// address/data/wren/q signals driven or consumed by the master.
interface data_mem_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req;
    logic                  we;
    logic [1:0]            size;
    logic                  unsigned_ld;
    logic [ADDR_WIDTH+1:0] byte_addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  done;
    logic                  err;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [31:0]           ram_data;
    logic                  ram_wren;
    logic [31:0]           ram_q;

    modport master (
        input  req, we, size, unsigned_ld, byte_addr, wdata, ram_q,
        output rdata, done, err, busy, ram_address, ram_data, ram_wren
    );

    modport slave (
        output req, we, size, unsigned_ld, byte_addr, wdata, ram_q,
        input  rdata, done, err, busy, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/data_mem_master.sv
// Byte/half/word load-store initiator for a single-port synchronous word RAM:
// sub-word stores are read-modify-write, sub-word loads are sign/zero extended.
module data_mem_master #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    data_mem_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    size_t                 size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [31:0]           ram_data_q, ram_data_d;
    logic                  ram_wren_q, ram_wren_d;

    logic  busy;
    logic  accept;
    logic  req_err;
    size_t req_size;

    function automatic logic [31:0] extract(input logic [31:0] word, input size_t sz,
                                            input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: return {{24{~uns & b[7]}}, b};
            SZ_HALF: return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                          input size_t sz, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (sz)
            SZ_BYTE: r[{lane, 3'b000} +: 8]     = wd[7:0];
            SZ_HALF: r[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign busy     = (state_q != S_IDLE) || done_q;
    assign accept   = bus.req && !busy;
    assign req_size = size_t'(bus.size);

    always_comb begin
        case (req_size)
            SZ_HALF: req_err = bus.byte_addr[0];
            SZ_WORD: req_err = (bus.byte_addr[1:0] != 2'b00);
            SZ_RSVD: req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        lane_d        = lane_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = ram_wren_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d       = bus.we;
                    size_d     = req_size;
                    unsigned_d = bus.unsigned_ld;
                    lane_d     = bus.byte_addr[1:0];
                    wdata_d    = bus.wdata;
                    if (req_err) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        ram_address_d = bus.byte_addr[ADDR_WIDTH+1:2];
                        if (bus.we && req_size == SZ_WORD) begin
                            ram_data_d = bus.wdata;
                            ram_wren_d = 1'b1;
                            state_d    = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: state_d = S_CAP;
            // RAM read data is valid here; sub-word stores merge, loads finish.
            S_CAP: begin
                if (we_q) begin
                    ram_data_d = merge(bus.ram_q, wdata_q, size_q, lane_q);
                    ram_wren_d = 1'b1;
                    state_d    = S_WR;
                end else begin
                    rdata_d = extract(bus.ram_q, size_q, unsigned_q, lane_q);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                ram_wren_d = 1'b0;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            size_q        <= SZ_BYTE;
            unsigned_q    <= 1'b0;
            lane_q        <= 2'b00;
            wdata_q       <= '0;
            rdata_q       <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            lane_q        <= lane_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            done_q        <= done_d;
            err_q         <= err_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_data_mem_master.sv
// Self-checking bench for data_mem_master: a synchronous RAM model, a
// transaction-level reference model, directed test-plan cases and random traffic.
module tb_data_mem_master;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic init_mem = 1'b1;

    data_mem_if #(.ADDR_WIDTH(AW)) bus ();

    data_mem_master #(.ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous single-port RAM: q is valid one cycle after the address.
    logic [31:0] ram [DEPTH];
    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (bus.ram_wren) begin
            ram[bus.ram_address] <= bus.ram_data;
        end
        bus.ram_q <= ram[bus.ram_address];
    end

    // Reference model: one pending transaction with a cycle countdown.
    logic [31:0] ref_mem [DEPTH];
    logic        exp_busy, exp_done, exp_err, exp_wren;
    logic [31:0] exp_rdata, exp_wdata;
    logic [AW-1:0] exp_waddr;
    logic        pend_valid, pend_err, pend_store;
    logic [31:0] pend_rdata, pend_new;
    logic [AW-1:0] pend_widx;
    int          m_cnt;

    initial begin
        logic        busy_pre;
        logic [1:0]  off, sz;
        logic [31:0] old, v, mask;
        int          sh, lat;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        exp_busy = 0; exp_done = 0; exp_err = 0; exp_wren = 0;
        exp_rdata = 0; exp_wdata = 0; exp_waddr = 0;
        pend_valid = 0; pend_err = 0; pend_store = 0;
        pend_rdata = 0; pend_new = 0; pend_widx = 0; m_cnt = 0;
        forever begin
            @(posedge clock);
            if (reset) begin
                exp_busy = 0; exp_done = 0; exp_err = 0; exp_wren = 0;
                exp_rdata = 0; pend_valid = 0; m_cnt = 0;
            end else begin
                busy_pre = exp_busy;
                exp_done = 0;
                if (pend_valid) m_cnt--;
                if (!busy_pre && bus.req) begin
                    off        = bus.byte_addr[1:0];
                    sz         = bus.size;
                    pend_widx  = bus.byte_addr[AW+1:2];
                    pend_err   = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
                    pend_store = bus.we;
                    old        = ref_mem[pend_widx];
                    sh         = int'(off) * 8;
                    v          = old >> sh;
                    if (sz == 2'd0) begin
                        v = v & 32'hFF;
                        if (!bus.unsigned_ld && v[7]) v = v | 32'hFFFF_FF00;
                    end else if (sz == 2'd1) begin
                        v = v & 32'hFFFF;
                        if (!bus.unsigned_ld && v[15]) v = v | 32'hFFFF_0000;
                    end
                    pend_rdata = v;
                    mask       = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
                    mask       = mask << sh;
                    pend_new   = (old & ~mask) | ((bus.wdata << sh) & mask);
                    if (pend_err)       lat = 1;
                    else if (!bus.we)   lat = 3;
                    else if (sz == 2'd2) lat = 2;
                    else                lat = 4;
                    m_cnt      = lat - 1;
                    pend_valid = 1;
                end
                if (pend_valid && m_cnt == 0) begin
                    exp_done = 1;
                    exp_err  = pend_err;
                    if (!pend_err && !pend_store) exp_rdata = pend_rdata;
                    if (!pend_err && pend_store)  ref_mem[pend_widx] = pend_new;
                    pend_valid = 0;
                end
                exp_busy  = pend_valid || exp_done;
                exp_wren  = pend_valid && pend_store && !pend_err && m_cnt == 1;
                exp_waddr = pend_widx;
                exp_wdata = pend_new;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    int            wren_count = 0;
    logic [AW-1:0] last_waddr = '0;
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("busy",  {31'b0, bus.busy},     {31'b0, exp_busy});
                check("done",  {31'b0, bus.done},     {31'b0, exp_done});
                check("rdata", bus.rdata,             exp_rdata);
                check("wren",  {31'b0, bus.ram_wren}, {31'b0, exp_wren});
                if (exp_done) check("err", {31'b0, bus.err}, {31'b0, exp_err});
                if (exp_wren) begin
                    check("ram_address", {24'b0, bus.ram_address}, {24'b0, exp_waddr});
                    check("ram_data",    bus.ram_data,             exp_wdata);
                end
                if (bus.ram_wren) begin
                    wren_count++;
                    last_waddr = bus.ram_address;
                end
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (exp_busy && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [AW+1:0] a, input logic [31:0] d,
                      output int lat, output int wr_delta);
        int w0;
        wait_idle();
        w0              = wren_count;
        bus.req         = 1'b1;
        bus.we          = w;
        bus.size        = sz;
        bus.unsigned_ld = u;
        bus.byte_addr   = a;
        bus.wdata       = d;
        @(posedge clock);
        #1 bus.req = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!bus.done && lat < 20);
        #1 wr_delta = wren_count - w0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wd, ndone, w0;
        logic [1:0] sz;
        logic [AW+1:0] a;
        int rr;

        bus.req = 0; bus.we = 0; bus.size = 0; bus.unsigned_ld = 0;
        bus.byte_addr = 0; bus.wdata = 0;
        repeat (3) @(negedge clock);

        check("rst_rdata",   bus.rdata,                 32'h0);
        check("rst_address", {24'b0, bus.ram_address}, 32'h0);
        check("rst_data",    bus.ram_data,              32'h0);
        check("rst_done",    {31'b0, bus.done},         32'h0);
        check("rst_err",     {31'b0, bus.err},          32'h0);
        check("rst_wren",    {31'b0, bus.ram_wren},     32'h0);
        check("rst_busy",    {31'b0, bus.busy},         32'h0);
        #2 reset = 0; init_mem = 0;
        @(negedge clock);

        // Word store then load.
        op(1, 2'b10, 0, 10'h010, 32'hDEAD_BEEF, lat, wd);
        check("st_word_lat",   lat, 2);
        check("st_word_wrens", wd, 1);
        check("st_word_addr",  {24'b0, last_waddr}, 32'h04);
        op(0, 2'b10, 0, 10'h010, 32'h0, lat, wd);
        check("ld_word_lat",   lat, 3);
        check("ld_word_rdata", bus.rdata, 32'hDEAD_BEEF);
        check("ld_word_err",   {31'b0, bus.err}, 32'h0);

        // Byte store read-modify-write.
        op(1, 2'b10, 0, 10'h020, 32'h1122_3344, lat, wd);
        op(1, 2'b00, 0, 10'h022, 32'hFFFF_FFAB, lat, wd);
        check("st_byte_lat",   lat, 4);
        check("st_byte_wrens", wd, 1);
        op(0, 2'b10, 0, 10'h020, 32'h0, lat, wd);
        check("rmw_word",      bus.rdata, 32'h11AB_3344);

        // Sub-word loads.
        op(1, 2'b10, 0, 10'h030, 32'h80FF_7F01, lat, wd);
        op(0, 2'b00, 0, 10'h032, 32'h0, lat, wd);
        check("ld_sbyte",      bus.rdata, 32'hFFFF_FFFF);
        check("ld_sbyte_lat",  lat, 3);
        op(0, 2'b00, 1, 10'h033, 32'h0, lat, wd);
        check("ld_ubyte",      bus.rdata, 32'h0000_0080);
        op(0, 2'b01, 0, 10'h030, 32'h0, lat, wd);
        check("ld_shalf_lo",   bus.rdata, 32'h0000_7F01);
        op(0, 2'b01, 0, 10'h032, 32'h0, lat, wd);
        check("ld_shalf_hi",   bus.rdata, 32'hFFFF_80FF);

        // Errors: misaligned half load, misaligned word store, reserved size.
        op(0, 2'b01, 0, 10'h005, 32'h0, lat, wd);
        check("err_half_lat",  lat, 1);
        check("err_half_err",  {31'b0, bus.err}, 32'h1);
        check("err_half_wren", wd, 0);
        op(1, 2'b10, 0, 10'h006, 32'h5555_AAAA, lat, wd);
        check("err_word_lat",  lat, 1);
        check("err_word_err",  {31'b0, bus.err}, 32'h1);
        check("err_word_wren", wd, 0);
        op(1, 2'b11, 0, 10'h040, 32'h1234_5678, lat, wd);
        check("err_rsvd_lat",  lat, 1);
        check("err_rsvd_err",  {31'b0, bus.err}, 32'h1);
        check("err_rsvd_wren", wd, 0);
        check("err_rdata_kept", bus.rdata, 32'hFFFF_80FF);

        // Continuous req with word stores: one acceptance per three cycles.
        wait_idle();
        w0            = wren_count;
        bus.req       = 1; bus.we = 1; bus.size = 2'b10;
        bus.byte_addr = {8'($urandom_range(0, 255)), 2'b00};
        bus.wdata     = $urandom;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        bus.req = 0;
        #1;
        check("hs_dones", ndone, 10);
        check("hs_wrens", wren_count - w0, 10);

        // Reset while ram_wren is high.
        wait_idle();
        bus.req = 1; bus.we = 1; bus.size = 2'b10;
        bus.byte_addr = 10'h040; bus.wdata = 32'hCAFE_F00D;
        @(posedge clock);
        #1 bus.req = 0;
        @(negedge clock);
        #2 check("rstwr_pre_wren", {31'b0, bus.ram_wren}, 32'h1);
        reset = 1;
        #1;
        check("rstwr_wren", {31'b0, bus.ram_wren}, 32'h0);
        check("rstwr_done", {31'b0, bus.done},     32'h0);
        check("rstwr_busy", {31'b0, bus.busy},     32'h0);
        @(negedge clock);
        #2 reset = 0;
        @(negedge clock);
        #1 check("rstwr_idle",  {31'b0, bus.busy}, 32'h0);
        check("rstwr_rdata", bus.rdata, 32'h0);
        op(0, 2'b10, 0, 10'h040, 32'h0, lat, wd);
        check("rstwr_nowrite", bus.rdata, init_word(16));

        // Random traffic; req changes freely, including while busy.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            rr = $urandom_range(0, 9);
            sz = (rr < 3) ? 2'd0 : (rr < 6) ? 2'd1 : (rr < 9) ? 2'd2 : 2'd3;
            a  = 10'($urandom);
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2'd1) a[0]   = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            bus.req         = ($urandom_range(0, 2) != 0);
            bus.we          = 1'($urandom);
            bus.size        = sz;
            bus.unsigned_ld = 1'($urandom);
            bus.byte_addr   = a;
            bus.wdata       = $urandom;
        end
        bus.req = 0;
        wait_idle();
        repeat (2) @(negedge clock);

        for (int i = 0; i < DEPTH; i++) check("mem_final", ram[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
